// File: rtl/ctrl_inicializar.sv
//==============================================================================
// Module   : ctrl_inicializar
// Brief    : RTC initialization sequencer. Steps the init decoder and issues
//            one 4-phase req/ack bus write per decoded step.
// Options  : INIT_REG1_EN adds the control-register-1 write (steps 10, 11).
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module ctrl_inicializar #(
    parameter int SETTLE_CYC = 2,
    parameter int ACK_TMO    = 255
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       start,
    output logic [3:0] ctrl_I,
    input  logic       Fin_I,
    input  logic       Op_I,
    input  logic       I_I,
    input  logic       AD_I,
    input  logic [3:0] Addr_I,
    input  logic [7:0] Data_I,
    output logic       bus_req,
    output logic       bus_ad,
    output logic       bus_i,
    output logic [3:0] bus_addr,
    output logic [7:0] bus_data,
    input  logic       bus_ack,
    output logic       busy,
    output logic       done,
    output logic       err
);

    localparam logic [3:0]  C_SETTLE  = 4'(SETTLE_CYC);
    localparam logic [15:0] C_ACK_TMO = 16'(ACK_TMO);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_SETTLE = 3'd1,
        S_REQ_HI = 3'd2,
        S_ACK_LO = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    state_t      r_state;
    logic [3:0]  r_settle_cnt;
    logic [15:0] r_tmo_cnt;

    function automatic logic [3:0] next_step(input logic [3:0] step);
        logic [3:0] nxt;
        nxt = step + 4'd1;
`ifdef INIT_REG1_EN
        case (step)
            4'd8:    nxt = 4'd10;
            4'd10:   nxt = 4'd11;
            4'd11:   nxt = 4'd9;
            default: nxt = step + 4'd1;
        endcase
`else
        if (step == 4'd8) begin
            nxt = 4'd9;
        end
`endif
        return nxt;
    endfunction

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= S_IDLE;
            r_settle_cnt <= 4'd0;
            r_tmo_cnt    <= 16'd0;
            ctrl_I       <= 4'd0;
            bus_req      <= 1'b0;
            bus_ad       <= 1'b0;
            bus_i        <= 1'b0;
            bus_addr     <= 4'd0;
            bus_data     <= 8'd0;
            busy         <= 1'b0;
            done         <= 1'b0;
            err          <= 1'b0;
        end else begin
            done <= 1'b0;
            case (r_state)
                // DONE is the single cycle carrying the done pulse; it accepts
                // a new start just like IDLE since busy is already low.
                S_IDLE, S_DONE: begin
                    ctrl_I  <= 4'd0;
                    r_state <= S_IDLE;
                    if (start) begin
                        ctrl_I       <= 4'd1;
                        busy         <= 1'b1;
                        err          <= 1'b0;
                        r_settle_cnt <= C_SETTLE;
                        r_state      <= S_SETTLE;
                    end
                end
                S_SETTLE: begin
                    if (r_settle_cnt <= 4'd1) begin
                        r_settle_cnt <= 4'd0;
                        // A step without a valid operation ends the program too.
                        if (Fin_I || !Op_I) begin
                            done    <= 1'b1;
                            busy    <= 1'b0;
                            ctrl_I  <= 4'd0;
                            r_state <= S_DONE;
                        end else begin
                            bus_ad    <= AD_I;
                            bus_i     <= I_I;
                            bus_addr  <= Addr_I;
                            bus_data  <= Data_I;
                            bus_req   <= 1'b1;
                            r_tmo_cnt <= C_ACK_TMO;
                            r_state   <= S_REQ_HI;
                        end
                    end else begin
                        r_settle_cnt <= r_settle_cnt - 4'd1;
                    end
                end
                S_REQ_HI: begin
                    if (bus_ack) begin
                        bus_req   <= 1'b0;
                        r_tmo_cnt <= C_ACK_TMO;
                        r_state   <= S_ACK_LO;
                    end else if (r_tmo_cnt <= 16'd1) begin
                        bus_req   <= 1'b0;
                        err       <= 1'b1;
                        busy      <= 1'b0;
                        ctrl_I    <= 4'd0;
                        r_tmo_cnt <= 16'd0;
                        r_state   <= S_IDLE;
                    end else begin
                        r_tmo_cnt <= r_tmo_cnt - 16'd1;
                    end
                end
                S_ACK_LO: begin
                    if (!bus_ack) begin
                        ctrl_I       <= next_step(ctrl_I);
                        r_settle_cnt <= C_SETTLE;
                        r_state      <= S_SETTLE;
                    end else if (r_tmo_cnt <= 16'd1) begin
                        bus_req   <= 1'b0;
                        err       <= 1'b1;
                        busy      <= 1'b0;
                        ctrl_I    <= 4'd0;
                        r_tmo_cnt <= 16'd0;
                        r_state   <= S_IDLE;
                    end else begin
                        r_tmo_cnt <= r_tmo_cnt - 16'd1;
                    end
                end
                default: begin
                    bus_req <= 1'b0;
                    busy    <= 1'b0;
                    ctrl_I  <= 4'd0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: doc/ctrl_inicializar.md
Name: ctrl_inicializar

Overview:
Sequencer for the RTC initialization program. Drives the 4-bit step code into the initialization decoder and samples its decoded outputs (Fin/Op/I/AD/Addr/Data). Issues one bus-write transaction per step to the multiplexed address/data bus driver over a 4-phase req/ack handshake. Sits between the top-level control FSM (start/busy/done/err) and the RTC bus driver.

Parameters:
SETTLE_CYC, 2, cycles the step code is held before decoder outputs are sampled (legal 1..15)
ACK_TMO, 255, max cycles waiting for each bus_ack edge before abort (legal 1..65535; 16-bit counter)

Ports:
clk  in  1  system clock, rising edge
reset_n  in  1  asynchronous, active-low reset
start  in  1  1-cycle request to run the init program; ignored while busy=1
ctrl_I  out  4  step code to decoder (registered)
Fin_I  in  1  decoder: end-of-program marker
Op_I  in  1  decoder: operation valid
I_I  in  1  decoder: init-mode flag, forwarded
AD_I  in  1  decoder: 0=address phase, 1=data phase
Addr_I  in  4  decoder: RTC register address
Data_I  in  8  decoder: RTC register data
bus_req  out  1  write request to bus driver
bus_ad  out  1  latched AD_I
bus_i  out  1  latched I_I
bus_addr  out  4  latched Addr_I
bus_data  out  8  latched Data_I
bus_ack  in  1  bus driver acknowledge (4-phase)
busy  out  1  program running
done  out  1  1-cycle pulse on normal completion
err  out  1  sticky ack-timeout flag; cleared by next accepted start

Behaviour:
- Reset (async, reset_n=0): state IDLE; ctrl_I=0, bus_req=0, bus_ad=0, bus_i=0, bus_addr=0, bus_data=0, busy=0, done=0, err=0, counters 0. Reset mid-program aborts immediately; no done/err.
- All outputs registered. States: IDLE, SETTLE, REQ_HI, ACK_LO, DONE.
- IDLE: ctrl_I=0. start=1 -> ctrl_I=1, busy=1, err=0, settle counter=SETTLE_CYC, go SETTLE.
- SETTLE: decrement counter; on reaching 0: if Fin_I=1 -> DONE. Else if Op_I=0 -> treat as Fin (DONE). Else latch AD_I/I_I/Addr_I/Data_I into bus_*, bus_req=1, timeout counter=ACK_TMO, go REQ_HI.
- REQ_HI: bus_req held 1 and bus_* stable. bus_ack=1 -> bus_req=0, reload timeout, go ACK_LO. Timeout reaches 0 -> abort.
- ACK_LO: wait bus_ack=0; then ctrl_I=next(ctrl_I), settle counter=SETTLE_CYC, go SETTLE. Timeout -> abort.
- next(): 1->2->...->8, 8->9. Step 9 decodes Fin_I=1 -> program end. Steps 0, 12-15 never issued.
- DONE: done=1 for exactly 1 cycle, busy=0, ctrl_I=0, return IDLE.
- Abort: bus_req=0, err=1, busy=0, ctrl_I=0, done stays 0, go IDLE.
- Latency: start sampled cycle 0 -> ctrl_I=1 at cycle 1 -> bus_req=1 at cycle 1+SETTLE_CYC. Zero-wait ack: each step costs SETTLE_CYC+3 cycles.
- start while busy: ignored, no effect on step/counter. bus_ack high in SETTLE/IDLE: ignored.
- bus_* hold last written value after completion/abort until next latch.

Optional Feature:
INIT_REG1_EN: defined -> sequence extended with control register 1 write: 8->10 (addr 1, data 0x04, AD=0), 10->11 (AD=1), 11->9; 10 bus transactions total. Undefined -> 8->9; steps 10/11 never issued; 8 transactions.

Test Plan:
- Reset, start, bus_ack immediate 1-cycle-delayed echo of bus_req -> 8 transactions: (addr,data,ad) = (2,0x10,0),(2,0x10,1),(2,0x00,0),(2,0x00,1),(3,0xD2,0),(3,0xD2,1),(0,0x00,0),(0,0x00,1); then one done pulse, busy=0, ctrl_I=0.
- Latency: SETTLE_CYC=2, start at cycle 0 -> ctrl_I=1 at cycle 1, bus_req rises cycle 3; bus_req stays high until ack for 5 stalled cycles.
- Timeout: ACK_TMO=10, bus_ack held 0 at step 3 -> bus_req falls after 10 cycles, err=1, done=0, ctrl_I=0; next start clears err and restarts at step 1.
- start pulsed at step 4 mid-run -> ignored; exactly 8 transactions, single done.
- reset_n low during REQ_HI of step 5 -> all outputs to reset values immediately; new start replays from step 1.
- With INIT_REG1_EN -> 10 transactions, last two (1,0x04,0),(1,0x04,1), then done.
